// File: rtl/ref_gen.sv
// Square-wave reference generator for an ADPLL input. The half-period is
// programmable, one-shot phase advance/retard commands are accepted, and stop is clean.
module ref_gen #(
    parameter int unsigned W        = 16,
    parameter int unsigned DEF_HALF = 50,
    parameter int unsigned MIN_HALF = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_op,
    input  logic [W-1:0] cfg_val,
    output logic         ref_signal,
    output logic         ref_rise,
    output logic         busy
);

    localparam int unsigned LW = W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_t;

    state_t        state_q, state_d;
    logic          ref_q, ref_d, rise_q, rise_d;
    logic [LW-1:0] cnt_q, cnt_d, lim_q, lim_d;
    logic [W-1:0]  half_q, half_d, pval_q, pval_d;
    logic          phalf_q, phalf_d, pphase_q, pphase_d;

    logic          accept, toggle, ref_next;
    logic [W-1:0]  clamped;
    logic [LW-1:0] base;
    logic [LW:0]   sum;

    assign accept  = cfg_valid & cfg_ready;
    assign clamped = (cfg_val < W'(MIN_HALF)) ? W'(MIN_HALF) : cfg_val;
    // >= rather than == so a phase advance below cnt still ends the phase next cycle
    assign toggle  = cnt_q >= (lim_q - LW'(1));

    always_comb begin
        unique case (state_q)
            StIdle:  cfg_ready = 1'b1;
            StRun:   cfg_ready = ~(phalf_q | pphase_q);
            default: cfg_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        rise_d   = 1'b0;
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        half_d   = half_q;
        pval_d   = pval_q;
        phalf_d  = phalf_q;
        pphase_d = 1'b0;
        ref_next = ref_q;
        base     = lim_q;
        sum      = '0;
        unique case (state_q)
            StIdle: begin
                if (accept && cfg_op == 2'd0) half_d = clamped;
                if (en) begin
                    state_d = StRun;
                    ref_d   = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                    lim_d   = {1'b0, half_d};
                end
            end
            StRun: begin
                cnt_d = cnt_q + LW'(1);
                if (toggle) begin
                    ref_next = ~ref_q;
                    rise_d   = ~ref_q;
                    cnt_d    = '0;
                    if (phalf_q) begin
                        half_d  = pval_q;
                        phalf_d = 1'b0;
                    end
                end
                if (accept && cfg_op == 2'd0) begin
                    if (toggle) begin
                        half_d = clamped;
                    end else begin
                        phalf_d = 1'b1;
                        pval_d  = clamped;
                    end
                end
                if (toggle) base = {1'b0, half_d};
                if (accept && cfg_op == 2'd1) begin
                    pphase_d = 1'b1;
                    base     = (base > {1'b0, cfg_val}) ? base - {1'b0, cfg_val} : LW'(1);
                end
                if (accept && cfg_op == 2'd2) begin
                    pphase_d = 1'b1;
                    sum      = {1'b0, base} + {2'b00, cfg_val};
                    base     = sum[LW] ? '1 : sum[LW-1:0];
                end
                lim_d = base;
                ref_d = ref_next;
                if (!en) begin
                    if (ref_next) begin
                        state_d = StStop;
                    end else begin
                        state_d = StIdle;
                        if (phalf_d) begin
                            half_d  = pval_d;
                            phalf_d = 1'b0;
                        end
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_q + LW'(1);
                if (toggle) begin
                    ref_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (phalf_q) begin
                        half_d  = pval_q;
                        phalf_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ref_q    <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
            lim_q    <= LW'(DEF_HALF);
            half_q   <= W'(DEF_HALF);
            pval_q   <= '0;
            phalf_q  <= 1'b0;
            pphase_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            half_q   <= half_d;
            pval_q   <= pval_d;
            phalf_q  <= phalf_d;
            pphase_q <= pphase_d;
        end
    end

    assign ref_signal = ref_q;
    assign ref_rise   = rise_q;
    assign busy       = (state_q != StIdle);

endmodule
